// File: rtl/ysyx_25020037_axi_arbiter_pkg.sv
// Shared AXI arbiter configuration: default bus widths, response codes and FSM state encoding.
package ysyx_25020037_axi_arbiter_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_IF_AR = 3'd1,
    ARB_IF_R  = 3'd2,
    ARB_LS_AR = 3'd3,
    ARB_LS_R  = 3'd4,
    ARB_LS_WR = 3'd5,
    ARB_LS_B  = 3'd6
  } arb_state_e;

endpackage

// File: rtl/ysyx_25020037_axi_arbiter.sv
// Purpose: merges IFU read and LSU read/write AXI masters onto one crossbar port, fixed priority LSU-W > LSU-R > IFU.
// Latency: grant in IDLE, xbar valid next cycle; grant back to IDLE in 3 cycles with a zero-wait slave.
// Backpressure: one transaction in flight; losing requests wait on their own valid; rready/bready pass straight through.
module ysyx_25020037_axi_arbiter
  import ysyx_25020037_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,

  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,

  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,

  output logic [ADDR_W-1:0]   xbar_araddr,
  output logic                xbar_arvalid,
  input  logic                xbar_arready,
  input  logic [DATA_W-1:0]   xbar_rdata,
  input  logic [1:0]          xbar_rresp,
  input  logic                xbar_rvalid,
  output logic                xbar_rready,

  output logic [ADDR_W-1:0]   xbar_awaddr,
  output logic                xbar_awvalid,
  input  logic                xbar_awready,
  output logic [DATA_W-1:0]   xbar_wdata,
  output logic [DATA_W/8-1:0] xbar_wstrb,
  output logic                xbar_wvalid,
  input  logic                xbar_wready,
  input  logic [1:0]          xbar_bresp,
  input  logic                xbar_bvalid,
  output logic                xbar_bready
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state;
  logic                hold;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                w_have;
  logic                aw_done;
  logic                w_done;

  logic can_grant, gnt_ls_w, gnt_ls_r, gnt_if;
  logic w_take;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic aw_done_nx, w_done_nx;
  logic in_if_r, in_ls_r, in_ls_b, in_ls_wr;

  assign in_if_r  = (state == ARB_IF_R);
  assign in_ls_r  = (state == ARB_LS_R);
  assign in_ls_b  = (state == ARB_LS_B);
  assign in_ls_wr = (state == ARB_LS_WR);

  // hold blocks a grant in the first IDLE cycle after a retire or a reset release
  assign can_grant = (state == ARB_IDLE) && !hold;
  assign gnt_ls_w  = can_grant && lsu_awvalid;
  assign gnt_ls_r  = can_grant && !lsu_awvalid && lsu_arvalid;
  assign gnt_if    = can_grant && !lsu_awvalid && !lsu_arvalid && ifu_arvalid;

  // W is taken alongside AW when already valid, otherwise on the first valid beat in LS_WR
  assign w_take = lsu_wvalid && (gnt_ls_w || (in_ls_wr && !w_have));

  assign ifu_arready = gnt_if;
  assign lsu_arready = gnt_ls_r;
  assign lsu_awready = gnt_ls_w;
  assign lsu_wready  = w_take;

  assign xbar_araddr  = addr_q;
  assign xbar_awaddr  = addr_q;
  assign xbar_wdata   = wdata_q;
  assign xbar_wstrb   = wstrb_q;
  assign xbar_arvalid = (state == ARB_IF_AR) || (state == ARB_LS_AR);
  assign xbar_awvalid = in_ls_wr && !aw_done;
  assign xbar_wvalid  = in_ls_wr && w_have && !w_done;
  assign xbar_rready  = (in_if_r && ifu_rready) || (in_ls_r && lsu_rready);
  assign xbar_bready  = in_ls_b && lsu_bready;

  assign ifu_rvalid = in_if_r && xbar_rvalid;
  assign ifu_rdata  = in_if_r ? xbar_rdata : '0;
  assign ifu_rresp  = in_if_r ? xbar_rresp : RESP_OKAY;
  assign lsu_rvalid = in_ls_r && xbar_rvalid;
  assign lsu_rdata  = in_ls_r ? xbar_rdata : '0;
  assign lsu_rresp  = in_ls_r ? xbar_rresp : RESP_OKAY;
  assign lsu_bvalid = in_ls_b && xbar_bvalid;
  assign lsu_bresp  = in_ls_b ? xbar_bresp : RESP_OKAY;

  assign ar_hs = xbar_arvalid && xbar_arready;
  assign r_hs  = xbar_rvalid && xbar_rready;
  assign aw_hs = xbar_awvalid && xbar_awready;
  assign w_hs  = xbar_wvalid && xbar_wready;
  assign b_hs  = xbar_bvalid && xbar_bready;

  assign aw_done_nx = aw_done || aw_hs;
  assign w_done_nx  = w_done || w_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      hold    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      w_have  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      hold <= 1'b0;
      if (w_take) begin
        wdata_q <= lsu_wdata;
        wstrb_q <= lsu_wstrb;
        w_have  <= 1'b1;
      end
      unique case (state)
        ARB_IDLE: begin
          if (gnt_ls_w) begin
            addr_q <= lsu_awaddr;
            state  <= ARB_LS_WR;
          end else if (gnt_ls_r) begin
            addr_q <= lsu_araddr;
            state  <= ARB_LS_AR;
          end else if (gnt_if) begin
            addr_q <= ifu_araddr;
            state  <= ARB_IF_AR;
          end
        end
        ARB_IF_AR: if (ar_hs) state <= ARB_IF_R;
        ARB_LS_AR: if (ar_hs) state <= ARB_LS_R;
        ARB_IF_R, ARB_LS_R: begin
          if (r_hs) begin
            state <= ARB_IDLE;
            hold  <= 1'b1;
          end
        end
        ARB_LS_WR: begin
          aw_done <= aw_done_nx;
          w_done  <= w_done_nx;
          if (aw_done_nx && w_done_nx) begin
            state   <= ARB_LS_B;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_have  <= 1'b0;
          end
        end
        ARB_LS_B: begin
          if (b_hs) begin
            state <= ARB_IDLE;
            hold  <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// Directed bench for the AXI arbiter: transaction table against a zero-wait crossbar model, plus priority, stall and reset sequences.
module tb_ysyx_25020037_axi_arbiter;

  localparam int K_IF = 0;
  localparam int K_LR = 1;
  localparam int K_LW = 2;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid, ifu_rready;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid, lsu_arready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid, lsu_rready;
  logic [31:0] lsu_awaddr;
  logic        lsu_awvalid, lsu_awready;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_wvalid, lsu_wready;
  logic [1:0]  lsu_bresp;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] xbar_araddr;
  logic        xbar_arvalid, xbar_arready;
  logic [31:0] xbar_rdata;
  logic [1:0]  xbar_rresp;
  logic        xbar_rvalid, xbar_rready;
  logic [31:0] xbar_awaddr;
  logic        xbar_awvalid, xbar_awready;
  logic [31:0] xbar_wdata;
  logic [3:0]  xbar_wstrb;
  logic        xbar_wvalid, xbar_wready;
  logic [1:0]  xbar_bresp;
  logic        xbar_bvalid, xbar_bready;

  ysyx_25020037_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .xbar_araddr(xbar_araddr), .xbar_arvalid(xbar_arvalid), .xbar_arready(xbar_arready),
    .xbar_rdata(xbar_rdata), .xbar_rresp(xbar_rresp), .xbar_rvalid(xbar_rvalid), .xbar_rready(xbar_rready),
    .xbar_awaddr(xbar_awaddr), .xbar_awvalid(xbar_awvalid), .xbar_awready(xbar_awready),
    .xbar_wdata(xbar_wdata), .xbar_wstrb(xbar_wstrb), .xbar_wvalid(xbar_wvalid), .xbar_wready(xbar_wready),
    .xbar_bresp(xbar_bresp), .xbar_bvalid(xbar_bvalid), .xbar_bready(xbar_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Zero-wait crossbar model: R one cycle after AR, B one cycle after both AW and W.
  logic [31:0] sl_rdata;
  logic [1:0]  sl_rresp, sl_bresp;
  logic        aw_got, w_got;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] wdata_log = '0;
  logic [3:0]  wstrb_log = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      xbar_rvalid <= 1'b0; xbar_rdata <= '0; xbar_rresp <= '0;
      xbar_bvalid <= 1'b0; xbar_bresp <= '0;
      aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      if (xbar_rvalid && xbar_rready) xbar_rvalid <= 1'b0;
      if (xbar_arvalid && xbar_arready) begin
        xbar_rvalid <= 1'b1; xbar_rdata <= sl_rdata; xbar_rresp <= sl_rresp;
        ar_cnt <= ar_cnt + 1;
      end
      if (xbar_bvalid && xbar_bready) xbar_bvalid <= 1'b0;
      if (xbar_awvalid && xbar_awready) aw_cnt <= aw_cnt + 1;
      if (xbar_wvalid && xbar_wready) begin
        w_cnt <= w_cnt + 1; wdata_log <= xbar_wdata; wstrb_log <= xbar_wstrb;
      end
      if ((aw_got || (xbar_awvalid && xbar_awready)) && (w_got || (xbar_wvalid && xbar_wready))) begin
        xbar_bvalid <= 1'b1; xbar_bresp <= sl_bresp; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (xbar_awvalid && xbar_awready) aw_got <= 1'b1;
        if (xbar_wvalid && xbar_wready) w_got <= 1'b1;
      end
    end
  end

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          w_dly;
    int          exp_rsp_cyc;
    int          exp_wv_cyc;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [11:0] ctl_outs();
    return {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
            lsu_bvalid, xbar_arvalid, xbar_rready, xbar_awvalid, xbar_wvalid, xbar_bready};
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int gnt_c = -1, xv_c = -1, rsp_c = -1, wv_c = -1;
    logic [31:0] xaddr = '0, rdat = '0;
    logic [1:0]  rrsp = '0;
    logic        quiet = 1'b1;
    logic        gnt, w_now;
    int ar0 = ar_cnt, aw0 = aw_cnt, w0 = w_cnt;
    @(negedge clk);
    sl_rdata = v.data; sl_rresp = v.resp; sl_bresp = v.resp;
    ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1;
    case (v.kind)
      K_IF: begin ifu_araddr = v.addr; ifu_arvalid = 1'b1; end
      K_LR: begin lsu_araddr = v.addr; lsu_arvalid = 1'b1; end
      default: begin
        lsu_awaddr = v.addr; lsu_awvalid = 1'b1;
        lsu_wdata = v.data; lsu_wstrb = v.strb; lsu_wvalid = (v.w_dly == 0);
      end
    endcase
    for (int c = 0; c < 20 && rsp_c < 0; c++) begin
      #1;
      gnt   = (v.kind == K_IF) ? ifu_arready : (v.kind == K_LR) ? lsu_arready : lsu_awready;
      w_now = lsu_wready;
      if (gnt && gnt_c < 0) gnt_c = c;
      if ((v.kind == K_LW ? xbar_awvalid : xbar_arvalid) && xv_c < 0) begin
        xv_c = c; xaddr = (v.kind == K_LW) ? xbar_awaddr : xbar_araddr;
      end
      if (xbar_wvalid && wv_c < 0) wv_c = c;
      case (v.kind)
        K_IF: begin
          if (ifu_rvalid && rsp_c < 0) begin rsp_c = c; rdat = ifu_rdata; rrsp = ifu_rresp; end
          if (lsu_arready || lsu_awready || lsu_wready || lsu_rvalid || lsu_bvalid ||
              lsu_rdata != 0 || lsu_rresp != 0 || lsu_bresp != 0) quiet = 1'b0;
        end
        K_LR: begin
          if (lsu_rvalid && rsp_c < 0) begin rsp_c = c; rdat = lsu_rdata; rrsp = lsu_rresp; end
          if (ifu_arready || ifu_rvalid || ifu_rdata != 0 || ifu_rresp != 0 ||
              lsu_awready || lsu_wready || lsu_bvalid || lsu_bresp != 0) quiet = 1'b0;
        end
        default: begin
          if (lsu_bvalid && rsp_c < 0) begin rsp_c = c; rrsp = lsu_bresp; end
          if (ifu_arready || ifu_rvalid || ifu_rdata != 0 || ifu_rresp != 0 ||
              lsu_arready || lsu_rvalid || lsu_rdata != 0 || lsu_rresp != 0) quiet = 1'b0;
        end
      endcase
      @(negedge clk);
      if (gnt) begin ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; end
      if (w_now) lsu_wvalid = 1'b0;
      if (v.kind == K_LW && c + 1 == v.w_dly) lsu_wvalid = 1'b1;
    end
    chk({tag, " grant_cycle"}, gnt_c, 0);
    chk({tag, " xbar_valid_cycle"}, xv_c, 1);
    chk({tag, " xbar_addr"}, xaddr, v.addr);
    chk({tag, " resp_cycle"}, rsp_c, v.exp_rsp_cyc);
    chk({tag, " resp"}, rrsp, v.resp);
    chk({tag, " other_slave_quiet"}, quiet, 1'b1);
    if (v.kind == K_LW) begin
      chk({tag, " xbar_wvalid_cycle"}, wv_c, v.exp_wv_cyc);
      chk({tag, " aw_count"}, aw_cnt - aw0, 1);
      chk({tag, " w_count"}, w_cnt - w0, 1);
      chk({tag, " wdata"}, wdata_log, v.data);
      chk({tag, " wstrb"}, wstrb_log, v.strb);
    end else begin
      chk({tag, " rdata"}, rdat, v.data);
      chk({tag, " ar_count"}, ar_cnt - ar0, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ls_g, if_g, ls_r, if_r, lg_c;
    logic [31:0] a1, a2;
    logic lg, ig, stable;

    rst = 1'b0;
    ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0; lsu_bready = 1'b1;
    xbar_arready = 1'b1; xbar_awready = 1'b1; xbar_wready = 1'b1;
    sl_rdata = '0; sl_rresp = '0; sl_bresp = '0;

    //        kind  addr           data           strb  resp  wdly rsp wv
    vecs[0] = '{K_IF, 32'h8000_0000, 32'h0000_0413, 4'h0, 2'd0, 0, 2, 0};
    vecs[1] = '{K_IF, 32'h0000_0000, 32'h0000_0000, 4'h0, 2'd3, 0, 2, 0};
    vecs[2] = '{K_LR, 32'hA000_03F8, 32'h1234_5678, 4'h0, 2'd2, 0, 2, 0};
    vecs[3] = '{K_LW, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 2'd0, 2, 4, 3};
    vecs[4] = '{K_LW, 32'h8000_2004, 32'h0000_00A5, 4'h1, 2'd2, 0, 2, 1};
    vecs[5] = '{K_LR, 32'h8000_0010, 32'hCAFE_F00D, 4'h0, 2'd0, 0, 2, 0};
    vecs[6] = '{K_LW, 32'h8000_2008, 32'h0000_BEEF, 4'h3, 2'd3, 1, 3, 2};

    // reset state, with a request pending that must not be granted
    @(negedge clk); @(negedge clk);
    ifu_arvalid = 1'b1;
    #1;
    chk("reset ctl outputs", ctl_outs(), 12'h000);
    chk("reset captured regs", {xbar_araddr, xbar_wdata, xbar_wstrb}, 68'h0);
    ifu_arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // simultaneous IFU and LSU read: LSU first, IFU one idle cycle after the LSU R handshake
    @(negedge clk);
    sl_rdata = 32'h0000_1111; sl_rresp = 2'd0;
    ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
    lsu_araddr = 32'hA000_03F8; lsu_arvalid = 1'b1;
    ls_g = -1; if_g = -1; ls_r = -1; if_r = -1; a1 = '0; a2 = '0;
    for (int c = 0; c < 20 && if_r < 0; c++) begin
      #1;
      lg = lsu_arready; ig = ifu_arready;
      if (lg && ls_g < 0) ls_g = c;
      if (ig && if_g < 0) if_g = c;
      if (lsu_rvalid && ls_r < 0) ls_r = c;
      if (ifu_rvalid && if_r < 0) if_r = c;
      if (c == 1) a1 = xbar_araddr;
      if (c == 5) a2 = xbar_araddr;
      @(negedge clk);
      if (lg) lsu_arvalid = 1'b0;
      if (ig) ifu_arvalid = 1'b0;
    end
    chk("prio lsu grant", ls_g, 0);
    chk("prio lsu rvalid", ls_r, 2);
    chk("prio ifu grant", if_g, 4);
    chk("prio ifu rvalid", if_r, 6);
    chk("prio first addr", a1, 32'hA000_03F8);
    chk("prio second addr", a2, 32'h8000_0004);

    // rready stalled 4 cycles; a late LSU request waits for the handshake
    @(negedge clk);
    sl_rdata = 32'h5A5A_0042; sl_rresp = 2'd2;
    ifu_araddr = 32'h8000_0100; ifu_arvalid = 1'b1; ifu_rready = 1'b0;
    lsu_araddr = 32'h8000_0200;
    stable = 1'b1; lg_c = -1;
    for (int c = 0; c < 20 && lg_c < 0; c++) begin
      #1;
      ig = ifu_arready; lg = lsu_arready;
      if (c >= 2 && c <= 5 && (!ifu_rvalid || ifu_rdata !== 32'h5A5A_0042 || ifu_rresp !== 2'd2)) stable = 1'b0;
      if (lg && lg_c < 0) lg_c = c;
      @(negedge clk);
      if (ig) ifu_arvalid = 1'b0;
      if (lg) lsu_arvalid = 1'b0;
      if (c == 1) lsu_arvalid = 1'b1;
      if (c == 5) ifu_rready = 1'b1;
    end
    chk("stall rdata stable", stable, 1'b1);
    chk("stall lsu grant cycle", lg_c, 8);
    ls_r = -1; a1 = '0;
    for (int c = 0; c < 10 && ls_r < 0; c++) begin
      #1;
      if (lsu_rvalid) begin ls_r = c; a1 = lsu_rdata; end
      @(negedge clk);
    end
    chk("stall lsu rvalid cycle", ls_r, 1);
    chk("stall lsu rdata", a1, 32'h5A5A_0042);

    // reset while waiting in LS_B, then a normal IFU read
    @(negedge clk);
    sl_bresp = 2'd0; lsu_bready = 1'b0;
    lsu_awaddr = 32'h8000_3000; lsu_awvalid = 1'b1;
    lsu_wdata = 32'h0BAD_F00D; lsu_wstrb = 4'hC; lsu_wvalid = 1'b1;
    #1;
    chk("rst_seq awready", {lsu_awready, lsu_wready}, 2'b11);
    @(negedge clk);
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_seq bvalid before reset", lsu_bvalid, 1'b1);
    chk("rst_seq captured wdata", xbar_wdata, 32'h0BAD_F00D);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_seq ctl outputs", ctl_outs(), 12'h000);
    chk("rst_seq captured regs", {xbar_awaddr, xbar_wdata, xbar_wstrb}, 68'h0);
    @(negedge clk);
    rst = 1'b1; lsu_bready = 1'b1;
    #1;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
    #1;
    chk("rst_seq no grant in release cycle", ifu_arready, 1'b0);
    ifu_arvalid = 1'b0;
    run_txn(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
